hs_fifo_pkt_guard: RTL

- Packet admission stage placed directly upstream of hs_fifo_sfifo's write port when packet mode and packet drop are enabled.
- Forwards a valid/ready packet stream to the FIFO, tracking the beat count of each packet.
- When a packet carries an upstream error or exceeds MAX_PKT_LEN, raises the FIFO drop signal on the offending beat, then silently discards the rest of that packet.
- Keeps saturating counters of forwarded and dropped packets.

---
 rtl/hs_fifo_pkt_guard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hs_fifo_pkt_guard.sv
// ---------------------------------------------------------------------------
// hs_fifo_pkt_guard
//
// Packet admission stage in front of the write port of hs_fifo_sfifo, for use
// when the FIFO runs with packet mode and packet drop enabled. Beats pass
// through a single output register. A packet that carries an upstream error,
// or that grows past MAX_PKT_LEN beats, is cut short. The offending beat goes
// out with m_drop=1 and m_last=1, and the rest of that packet is swallowed.
// Two saturating counters track forwarded and dropped packets.
//
// Ports:
//   clk, aresetn        clock, asynchronous active-low reset
//   s_valid/s_ready     upstream handshake
//   s_data              upstream beat (DATA_TYPE, passed through unmodified)
//   s_last, s_err       end-of-packet marker, upstream error flag
//   m_valid/m_ready     handshake toward FIFO wvalid/wready
//   m_data, m_last      toward FIFO wdata/wlast
//   m_drop              toward FIFO wdrop (only meaningful while m_valid=1)
//   pkt_cnt, drop_cnt   packets forwarded whole / packets dropped (saturating)
// ---------------------------------------------------------------------------
module hs_fifo_pkt_guard #(
    parameter type DATA_TYPE   = logic,
    parameter int  MAX_PKT_LEN = 256,
    parameter int  CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  DATA_TYPE             s_data,
    input  logic                 s_last,
    input  logic                 s_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output DATA_TYPE             m_data,
    output logic                 m_last,
    output logic                 m_drop,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int LEN_WIDTH = $clog2(MAX_PKT_LEN + 1);
    // One extra bit so that beat MAX_PKT_LEN+1 can be represented and compared.
    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(MAX_PKT_LEN);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DISCARD
    } state_t;

    state_t               state, state_next;
    logic [LEN_WIDTH-1:0] len, len_next;
    logic [LEN_WIDTH:0]   len_inc;
    logic                 accept;
    logic                 m_fire;
    logic                 bad;
    logic                 load;
    logic                 load_last;
    logic                 load_drop;

    // While discarding, beats are swallowed without touching the output
    // register, so upstream never has to wait for the FIFO.
    assign s_ready = (state == DISCARD) || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign len_inc = {1'b0, len} + (LEN_WIDTH + 1)'(1);
    // A beat that lands exactly on MAX_PKT_LEN is legal whether or not it is
    // the last one; only the beat after that overflows.
    assign bad     = s_err || (len_inc > MAX_LEN);

    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        len_next   = len;
        load       = 1'b0;
        load_last  = 1'b0;
        load_drop  = 1'b0;
        if (accept) begin
            case (state)
                IDLE, PASS: begin
                    load = 1'b1;
                    if (bad) begin
                        load_last  = 1'b1;
                        load_drop  = 1'b1;
                        len_next   = '0;
                        state_next = s_last ? IDLE : DISCARD;
                    end else if (s_last) begin
                        load_last  = 1'b1;
                        len_next   = '0;
                        state_next = IDLE;
                    end else begin
                        // Not bad, so len_inc <= MAX_PKT_LEN and fits in len.
                        len_next   = len_inc[LEN_WIDTH-1:0];
                        state_next = PASS;
                    end
                end
                DISCARD: begin
                    if (s_last) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            len      <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_drop   <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_next;
            len   <= len_next;

            // A load only happens when the register is empty or draining this
            // cycle, so it never overwrites a beat still waiting on m_ready.
            if (load) begin
                m_valid <= 1'b1;
                m_last  <= load_last;
                m_drop  <= load_drop;
            end else if (m_fire) begin
                m_valid <= 1'b0;
            end

            // Every drop beat also carries m_last, so the two cases below are
            // exclusive and at most one counter moves per cycle.
            if (m_fire && m_last && !m_drop && (pkt_cnt != '1))
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            if (m_fire && m_drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    // NOTE: the data path carries no reset; it is qualified by m_valid, and
    // leaving it unreset keeps the reset net off every data bit.
    always_ff @(posedge clk) begin
        if (load) m_data <= s_data;
    end

endmodule
